// File: rtl/bsg_chip_pkg.sv
// Chip-level constants shared by the memory-controller link blocks.
// The receive path takes its default payload width and token decimation from here.
package bsg_chip_pkg;

    localparam int mc_fwd_width_lp           = 32;
    localparam int mc_lg_token_decimation_lp = 2;

endpackage

// File: rtl/bsg_chip_mc_link_rx_fifo.sv
// 1r1w receive buffer: els_p x width_p storage, wrapping pointers and a registered
// occupancy count. Writes become visible on the following cycle (no fall-through).
module bsg_chip_mc_link_rx_fifo #(
    parameter int width_p = 32,
    parameter int els_p   = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         enq_i,
    input  logic [width_p-1:0]           data_i,
    input  logic                         deq_i,
    output logic                         full_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int lg_els_lp = $clog2(els_p);
    localparam int cnt_w_lp  = $clog2(els_p+1);

    logic [width_p-1:0]   r_mem [els_p];
    logic [lg_els_lp-1:0] r_wptr;
    logic [lg_els_lp-1:0] r_rptr;
    logic [cnt_w_lp-1:0]  r_count;
    logic                 r_v;
    logic                 w_full;
    logic                 w_enq;
    logic                 w_deq;

    // Full is judged on the start-of-cycle count, so a same-cycle dequeue never frees a slot.
    assign w_full = (r_count == cnt_w_lp'(els_p));
    assign w_enq  = enq_i & ~w_full;
    assign w_deq  = deq_i & r_v;

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_v     <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + lg_els_lp'(1);
            end
            if (w_deq) begin
                r_rptr <= r_rptr + lg_els_lp'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + cnt_w_lp'(1);
                r_v     <= 1'b1;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - cnt_w_lp'(1);
                r_v     <= (r_count != cnt_w_lp'(1));
            end
        end
    end

    assign full_o  = w_full;
    assign v_o     = r_v;
    assign data_o  = r_mem[r_rptr];
    assign count_o = r_count;

endmodule

// File: rtl/bsg_chip_mc_link_token_rx.sv
// Credit-based link receiver: buffers incoming packets, returns one token per
// 2^lg_token_decimation_p dequeues, and flags packets that arrive while full.
module bsg_chip_mc_link_token_rx
    import bsg_chip_pkg::*;
#(
    parameter int width_p               = mc_fwd_width_lp,
    parameter int els_p                 = 8,
    parameter int lg_token_decimation_p = mc_lg_token_decimation_lp
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         link_v_i,
    input  logic [width_p-1:0]           link_data_i,
    output logic                         link_token_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         ready_i,
    output logic                         overflow_o,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    logic w_full;
    logic w_fifo_v;
    logic w_deq;
    logic r_token;
    logic r_overflow;

    assign w_deq = w_fifo_v & ready_i;

    bsg_chip_mc_link_rx_fifo #(
        .width_p (width_p),
        .els_p   (els_p)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enq_i     (link_v_i),
        .data_i    (link_data_i),
        .deq_i     (w_deq),
        .full_o    (w_full),
        .v_o       (w_fifo_v),
        .data_o    (data_o),
        .count_o   (count_o)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_overflow <= 1'b0;
        end else if (link_v_i && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Token pulses only on consumer dequeues, so dropped packets never return credit.
    if (lg_token_decimation_p == 0) begin : g_token_every
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_token <= 1'b0;
            end else begin
                r_token <= w_deq;
            end
        end
    end else begin : g_token_decimated
        logic [lg_token_decimation_p-1:0] r_deq_cnt;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_deq_cnt <= '0;
                r_token   <= 1'b0;
            end else begin
                if (w_deq) begin
                    r_deq_cnt <= r_deq_cnt + lg_token_decimation_p'(1);
                end
                r_token <= w_deq & (&r_deq_cnt);
            end
        end
    end

    assign link_token_o = r_token;
    assign v_o          = w_fifo_v;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_bsg_chip_mc_link_token_rx.sv
// Scenario bench for the link token receiver: a negedge scoreboard tracks occupancy,
// packet order and token timing while per-scenario tasks check milestones.
module tb_bsg_chip_mc_link_token_rx;

    localparam int W   = 16;
    localparam int ELS = 8;
    localparam int LG  = 2;
    localparam int CW  = $clog2(ELS+1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          link_v;
    logic [W-1:0]  link_data;
    logic          link_token;
    logic          v;
    logic [W-1:0]  data;
    logic          ready;
    logic          overflow;
    logic [CW-1:0] count;

    int vectors     = 0;
    int miscompares = 0;
    int tok_seen    = 0;
    int deq_seen    = 0;

    logic [W-1:0]  sb [$];
    logic [CW-1:0] m_count = '0;
    logic          m_ovf   = 1'b0;
    logic          m_tok   = 1'b0;
    logic [LG-1:0] m_cnt   = '0;

    always #5 clk = ~clk;

    bsg_chip_mc_link_token_rx #(
        .width_p               (W),
        .els_p                 (ELS),
        .lg_token_decimation_p (LG)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .link_v_i     (link_v),
        .link_data_i  (link_data),
        .link_token_o (link_token),
        .v_o          (v),
        .data_o       (data),
        .ready_i      (ready),
        .overflow_o   (overflow),
        .count_o      (count)
    );

    // Reference model, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin : monitor
        logic          dq;
        logic          acc;
        logic [W-1:0]  exp_data;
        if (!reset_n) begin
            sb.delete();
            m_count = '0;
            m_ovf   = 1'b0;
            m_tok   = 1'b0;
            m_cnt   = '0;
            vectors++;
            if ({v, link_token, overflow} !== 3'b000 || count !== '0) begin
                miscompares++;
                $display("FAIL mon_reset t=%0t got v=%b tok=%b ovf=%b cnt=%0d want all 0",
                         $time, v, link_token, overflow, count);
            end
        end else begin
            vectors++;
            if (v !== (m_count != '0)) begin
                miscompares++;
                $display("FAIL mon_v t=%0t got=%b want=%b", $time, v, (m_count != '0));
            end
            vectors++;
            if (count !== m_count) begin
                miscompares++;
                $display("FAIL mon_count t=%0t got=%0d want=%0d", $time, count, m_count);
            end
            vectors++;
            if (overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL mon_overflow t=%0t got=%b want=%b", $time, overflow, m_ovf);
            end
            vectors++;
            if (link_token !== m_tok) begin
                miscompares++;
                $display("FAIL mon_token t=%0t got=%b want=%b", $time, link_token, m_tok);
            end
            if (link_token === 1'b1) tok_seen++;

            dq  = ready && (m_count != '0);
            acc = link_v && (m_count < CW'(ELS));
            if (dq) begin
                exp_data = sb.pop_front();
                deq_seen++;
                vectors++;
                if (data !== exp_data) begin
                    miscompares++;
                    $display("FAIL mon_data t=%0t got=%h want=%h", $time, data, exp_data);
                end
            end
            if (acc) sb.push_back(link_data);
            else if (link_v) m_ovf = 1'b1;
            m_tok = dq && (m_cnt == {LG{1'b1}});
            if (dq) m_cnt = m_cnt + 1'b1;
            m_count = m_count + CW'(acc) - CW'(dq);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        link_v    = 1'b0;
        link_data = '0;
        ready     = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        link_v    = 1'b0;
        link_data = '0;
        ready     = 1'b0;
        #2;
        vectors++;
        if ({v, link_token, overflow} !== 3'b000 || count !== '0) begin
            miscompares++;
            $display("FAIL reset_state got v=%b tok=%b ovf=%b cnt=%0d want all 0",
                     v, link_token, overflow, count);
        end
        do_reset();
    endtask

    task automatic test_basic();
        int t0;
        do_reset();
        t0    = tok_seen;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            link_v    = 1'b1;
            link_data = W'(16'hA0 + i);
            if (i == 0) begin
                vectors++;
                if (v !== 1'b0) begin
                    miscompares++;
                    $display("FAIL basic_no_fallthrough got v=%b want=0", v);
                end
            end
            step();
            vectors++;
            if (v !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_valid i=%0d got v=%b want=1", i, v);
            end
        end
        link_v = 1'b0;
        repeat (4) step();
        vectors++;
        if (tok_seen - t0 != 1) begin
            miscompares++;
            $display("FAIL basic_tokens got=%0d want=1", tok_seen - t0);
        end
        vectors++;
        if (count !== '0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL basic_drained got cnt=%0d pending=%0d want 0/0", count, sb.size());
        end
    endtask

    task automatic test_overflow();
        int t0;
        do_reset();
        t0 = tok_seen;
        for (int i = 0; i < ELS; i++) begin
            link_v    = 1'b1;
            link_data = W'(16'h0100 + i);
            step();
        end
        link_v = 1'b0;
        vectors++;
        if (count !== CW'(ELS) || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_full got cnt=%0d ovf=%b want 8/0", count, overflow);
        end
        link_v    = 1'b1;
        link_data = W'(16'hDEAD);
        step();
        link_v = 1'b0;
        step();
        vectors++;
        if (overflow !== 1'b1 || count !== CW'(ELS) || tok_seen != t0) begin
            miscompares++;
            $display("FAIL ovf_drop got ovf=%b cnt=%0d tok=%0d want 1/8/0",
                     overflow, count, tok_seen - t0);
        end
        // Enqueue into a full buffer is rejected even when a dequeue happens that cycle.
        link_v    = 1'b1;
        link_data = W'(16'hBEEF);
        ready     = 1'b1;
        step();
        link_v = 1'b0;
        ready  = 1'b0;
        vectors++;
        if (count !== CW'(ELS-1) || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_simul got cnt=%0d ovf=%b want 7/1", count, overflow);
        end
        ready = 1'b1;
        repeat (10) step();
        vectors++;
        if (count !== '0 || overflow !== 1'b1 || tok_seen - t0 != 2) begin
            miscompares++;
            $display("FAIL ovf_drain got cnt=%0d ovf=%b tok=%0d want 0/1/2",
                     count, overflow, tok_seen - t0);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            link_v    = 1'b1;
            link_data = W'(16'h0200 + i);
            step();
        end
        t0 = tok_seen;
        for (int i = 0; i < 20; i++) begin
            link_v    = 1'b1;
            ready     = 1'b1;
            link_data = W'(16'h0300 + i);
            step();
            vectors++;
            if (count !== CW'(3)) begin
                miscompares++;
                $display("FAIL b2b_count i=%0d got=%0d want=3", i, count);
            end
        end
        link_v = 1'b0;
        ready  = 1'b0;
        repeat (2) step();
        vectors++;
        if (tok_seen - t0 != 5) begin
            miscompares++;
            $display("FAIL b2b_tokens got=%0d want=5", tok_seen - t0);
        end
        ready = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_random_credit();
        int t0, d0, credits, sent, cycles;
        do_reset();
        t0      = tok_seen;
        d0      = deq_seen;
        credits = 8;
        sent    = 0;
        cycles  = 0;
        while ((sent < 1000 || count !== '0) && cycles < 20000) begin
            if (link_token === 1'b1) credits += 4;
            if (sent < 1000 && credits > 0 && $urandom_range(3) != 0) begin
                link_v    = 1'b1;
                link_data = W'(sent);
                sent++;
                credits--;
            end else begin
                link_v = 1'b0;
            end
            ready = 1'($urandom_range(1));
            step();
            cycles++;
        end
        link_v = 1'b0;
        ready  = 1'b1;
        repeat (2) step();
        vectors++;
        if (cycles >= 20000) begin
            miscompares++;
            $display("FAIL rand_timeout got cycles=%0d want <20000", cycles);
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_overflow got=%b want=0", overflow);
        end
        vectors++;
        if (deq_seen - d0 != 1000) begin
            miscompares++;
            $display("FAIL rand_dequeues got=%0d want=1000", deq_seen - d0);
        end
        vectors++;
        if (tok_seen - t0 != 250) begin
            miscompares++;
            $display("FAIL rand_tokens got=%0d want=250", tok_seen - t0);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        do_reset();
        for (int i = 0; i < ELS; i++) begin
            link_v    = 1'b1;
            link_data = W'(16'h0400 + i);
            step();
        end
        link_v = 1'b0;
        ready  = 1'b1;
        repeat (3) step();
        ready = 1'b0;
        vectors++;
        if (count !== CW'(5)) begin
            miscompares++;
            $display("FAIL mid_preload got cnt=%0d want=5", count);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({v, link_token, overflow} !== 3'b000 || count !== '0) begin
            miscompares++;
            $display("FAIL mid_async_reset got v=%b tok=%b ovf=%b cnt=%0d want all 0",
                     v, link_token, overflow, count);
        end
        repeat (2) step();
        reset_n = 1'b1;
        t0      = tok_seen;
        ready   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            link_v    = 1'b1;
            link_data = W'(16'h0500 + i);
            step();
        end
        link_v = 1'b0;
        repeat (4) step();
        vectors++;
        if (tok_seen - t0 != 1) begin
            miscompares++;
            $display("FAIL mid_tokens got=%0d want=1", tok_seen - t0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_random_credit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
